// File: rtl/alu_i_reservation_station.sv
// Integer-ALU reservation station: captures pending operands from the CDB and issues ready instructions.
// Optional build macro ALU_RS_OLDEST_FIRST_EN selects oldest-first issue via an age matrix.
module alu_i_reservation_station #(
    parameter int ROBSIZE  = 8,
    parameter int RS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_flush,
    input  logic                          i_dispatch_en,
    output logic                          o_full,
    output logic [$clog2(RS_DEPTH+1)-1:0] o_count,
    input  logic [ROBSIZE-1:0]            i_rob_addr,
    input  logic [4:0]                    i_alu_opcode,
    input  logic                          i_addr_cal,
    input  logic                          i_con_branch_comp,
    input  logic                          i_rs1_ready,
    input  logic                          i_rs2_ready,
    input  logic [31:0]                   i_rs1_value,
    input  logic [31:0]                   i_rs2_value,
    input  logic [ROBSIZE-1:0]            i_rs1_tag,
    input  logic [ROBSIZE-1:0]            i_rs2_tag,
    input  logic                          i_cdb_valid,
    input  logic [ROBSIZE-1:0]            i_cdb_rob_addr,
    input  logic [31:0]                   i_cdb_value,
    input  logic                          i_alu_busy,
    output logic                          o_ex_en,
    output logic [ROBSIZE-1:0]            o_rob_addr,
    output logic [31:0]                   o_rs1_value,
    output logic [31:0]                   o_rs2_value,
    output logic [4:0]                    o_alu_opcode,
    output logic                          o_addr_cal,
    output logic                          o_con_branch_comp
);

    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(RS_DEPTH + 1);

    logic [RS_DEPTH-1:0] valid_q;
    logic [RS_DEPTH-1:0] rs1_rdy_q;
    logic [RS_DEPTH-1:0] rs2_rdy_q;
    logic [RS_DEPTH-1:0] addr_cal_q;
    logic [RS_DEPTH-1:0] cbc_q;
    logic [ROBSIZE-1:0]  rob_q     [RS_DEPTH];
    logic [4:0]          op_q      [RS_DEPTH];
    logic [31:0]         rs1_val_q [RS_DEPTH];
    logic [31:0]         rs2_val_q [RS_DEPTH];
    logic [ROBSIZE-1:0]  rs1_tag_q [RS_DEPTH];
    logic [ROBSIZE-1:0]  rs2_tag_q [RS_DEPTH];
    logic [CW-1:0]       count_q;

    logic [RS_DEPTH-1:0] cand;
    logic [IW-1:0]       free_idx;
    logic [IW-1:0]       sel_idx;
    logic                free_found;
    logic                disp_acc;
    logic                fwd1;
    logic                fwd2;

    assign o_full   = &valid_q;
    assign o_count  = count_q;
    assign cand     = valid_q & rs1_rdy_q & rs2_rdy_q;
    assign o_ex_en  = !i_alu_busy && (|cand) && !i_flush;
    assign disp_acc = i_dispatch_en && !o_full && !i_flush;
    assign fwd1     = !i_rs1_ready && i_cdb_valid && (i_cdb_rob_addr == i_rs1_tag);
    assign fwd2     = !i_rs2_ready && i_cdb_valid && (i_cdb_rob_addr == i_rs2_tag);

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IW'(i);
                free_found = 1'b1;
            end
        end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
    logic                is_oldest;

    always_comb begin
        sel_idx   = '0;
        is_oldest = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            is_oldest = cand[i];
            for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                if (j != i && cand[j] && !older_q[i][j])
                    is_oldest = 1'b0;
            end
            if (is_oldest)
                sel_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++)
                older_q[i] <= '0;
        end else if (disp_acc) begin
            for (int unsigned j = 0; j < RS_DEPTH; j++)
                older_q[j][free_idx] <= 1'b1;
            older_q[free_idx] <= '0;
        end
    end
`else
    logic sel_found;

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (cand[i] && !sel_found) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        o_rob_addr        = '0;
        o_rs1_value       = '0;
        o_rs2_value       = '0;
        o_alu_opcode      = '0;
        o_addr_cal        = 1'b0;
        o_con_branch_comp = 1'b0;
        if (o_ex_en) begin
            o_rob_addr        = rob_q[sel_idx];
            o_rs1_value       = rs1_val_q[sel_idx];
            o_rs2_value       = rs2_val_q[sel_idx];
            o_alu_opcode      = op_q[sel_idx];
            o_addr_cal        = addr_cal_q[sel_idx];
            o_con_branch_comp = cbc_q[sel_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= '0;
            rs1_rdy_q  <= '0;
            rs2_rdy_q  <= '0;
            addr_cal_q <= '0;
            cbc_q      <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                rob_q[i]     <= '0;
                op_q[i]      <= '0;
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
                rs1_tag_q[i] <= '0;
                rs2_tag_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (valid_q[i] && !rs1_rdy_q[i] && i_cdb_valid && i_cdb_rob_addr == rs1_tag_q[i]) begin
                    rs1_rdy_q[i] <= 1'b1;
                    rs1_val_q[i] <= i_cdb_value;
                end
                if (valid_q[i] && !rs2_rdy_q[i] && i_cdb_valid && i_cdb_rob_addr == rs2_tag_q[i]) begin
                    rs2_rdy_q[i] <= 1'b1;
                    rs2_val_q[i] <= i_cdb_value;
                end
            end
            if (i_flush) begin
                valid_q <= '0;
                count_q <= '0;
            end else begin
                // issued entry is always valid and the free slot never is, so these never collide
                if (o_ex_en)
                    valid_q[sel_idx] <= 1'b0;
                if (disp_acc) begin
                    valid_q[free_idx]    <= 1'b1;
                    rob_q[free_idx]      <= i_rob_addr;
                    op_q[free_idx]       <= i_alu_opcode;
                    addr_cal_q[free_idx] <= i_addr_cal;
                    cbc_q[free_idx]      <= i_con_branch_comp;
                    rs1_rdy_q[free_idx]  <= i_rs1_ready | fwd1;
                    rs2_rdy_q[free_idx]  <= i_rs2_ready | fwd2;
                    rs1_val_q[free_idx]  <= fwd1 ? i_cdb_value : i_rs1_value;
                    rs2_val_q[free_idx]  <= fwd2 ? i_cdb_value : i_rs2_value;
                    rs1_tag_q[free_idx]  <= i_rs1_tag;
                    rs2_tag_q[free_idx]  <= i_rs2_tag;
                end
                count_q <= count_q + CW'(disp_acc) - CW'(o_ex_en);
            end
        end
    end

endmodule

// File: tb/tb_alu_i_reservation_station.sv
// Directed bench for alu_i_reservation_station: table of single-instruction vectors plus multi-cycle sequences.
module tb_alu_i_reservation_station;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_flush;
    logic        i_dispatch_en;
    logic        o_full;
    logic [2:0]  o_count;
    logic [7:0]  i_rob_addr;
    logic [4:0]  i_alu_opcode;
    logic        i_addr_cal;
    logic        i_con_branch_comp;
    logic        i_rs1_ready;
    logic        i_rs2_ready;
    logic [31:0] i_rs1_value;
    logic [31:0] i_rs2_value;
    logic [7:0]  i_rs1_tag;
    logic [7:0]  i_rs2_tag;
    logic        i_cdb_valid;
    logic [7:0]  i_cdb_rob_addr;
    logic [31:0] i_cdb_value;
    logic        i_alu_busy;
    logic        o_ex_en;
    logic [7:0]  o_rob_addr;
    logic [31:0] o_rs1_value;
    logic [31:0] o_rs2_value;
    logic [4:0]  o_alu_opcode;
    logic        o_addr_cal;
    logic        o_con_branch_comp;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_i_reservation_station #(.ROBSIZE(8), .RS_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_dispatch_en(i_dispatch_en),
        .o_full(o_full), .o_count(o_count), .i_rob_addr(i_rob_addr),
        .i_alu_opcode(i_alu_opcode), .i_addr_cal(i_addr_cal),
        .i_con_branch_comp(i_con_branch_comp), .i_rs1_ready(i_rs1_ready),
        .i_rs2_ready(i_rs2_ready), .i_rs1_value(i_rs1_value), .i_rs2_value(i_rs2_value),
        .i_rs1_tag(i_rs1_tag), .i_rs2_tag(i_rs2_tag), .i_cdb_valid(i_cdb_valid),
        .i_cdb_rob_addr(i_cdb_rob_addr), .i_cdb_value(i_cdb_value),
        .i_alu_busy(i_alu_busy), .o_ex_en(o_ex_en), .o_rob_addr(o_rob_addr),
        .o_rs1_value(o_rs1_value), .o_rs2_value(o_rs2_value),
        .o_alu_opcode(o_alu_opcode), .o_addr_cal(o_addr_cal),
        .o_con_branch_comp(o_con_branch_comp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rob;
        logic [4:0]  op;
        logic        ac;
        logic        cb;
        logic [31:0] v1;
        logic [31:0] v2;
    } vec_t;

    vec_t tbl [4];
    logic [7:0] drain_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_dispatch_en = 1'b0;
        i_flush       = 1'b0;
        i_cdb_valid   = 1'b0;
    endtask

    task automatic dispatch(input logic [7:0] rob, input logic [4:0] op, input logic ac, input logic cb,
                            input logic r1, input logic [31:0] v1, input logic [7:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [7:0] t2);
        i_dispatch_en     = 1'b1;
        i_rob_addr        = rob;
        i_alu_opcode      = op;
        i_addr_cal        = ac;
        i_con_branch_comp = cb;
        i_rs1_ready       = r1;
        i_rs1_value       = v1;
        i_rs1_tag         = t1;
        i_rs2_ready       = r2;
        i_rs2_value       = v2;
        i_rs2_tag         = t2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{rob: 8'd2,  op: 5'd0,  ac: 1'b0, cb: 1'b0, v1: 32'd3,          v2: 32'd5};
        tbl[1] = '{rob: 8'd9,  op: 5'd7,  ac: 1'b1, cb: 1'b0, v1: 32'hDEADBEEF,   v2: 32'h0};
        tbl[2] = '{rob: 8'hFF, op: 5'd31, ac: 1'b0, cb: 1'b1, v1: 32'hFFFFFFFF,   v2: 32'h80000000};
        tbl[3] = '{rob: 8'd0,  op: 5'd12, ac: 1'b1, cb: 1'b1, v1: 32'h00000001,   v2: 32'h7FFFFFFF};
`ifdef ALU_RS_OLDEST_FIRST_EN
        drain_exp = '{8'd11, 8'd12, 8'd13, 8'd20};
`else
        drain_exp = '{8'd20, 8'd11, 8'd12, 8'd13};
`endif

        rstn = 1'b0;
        idle_in();
        i_alu_busy = 1'b0;
        dispatch(8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0);
        i_dispatch_en  = 1'b0;
        i_cdb_rob_addr = '0;
        i_cdb_value    = '0;
        #12;
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_ex_en", 32'(o_ex_en), 32'd0);
        chk("rst_rob",   32'(o_rob_addr), 32'd0);
        step();
        rstn = 1'b1;
        step();

        // single ready instruction: dispatch, issue next cycle, drain
        for (int k = 0; k < 4; k++) begin
            dispatch(tbl[k].rob, tbl[k].op, tbl[k].ac, tbl[k].cb, 1'b1, tbl[k].v1, 8'd0, 1'b1, tbl[k].v2, 8'd0);
            #1;
            chk("tbl_no_bypass", 32'(o_ex_en), 32'd0);
            step();
            idle_in();
            #1;
            chk("tbl_count1", 32'(o_count), 32'd1);
            chk("tbl_ex_en", 32'(o_ex_en), 32'd1);
            chk("tbl_rob", 32'(o_rob_addr), 32'(tbl[k].rob));
            chk("tbl_op", 32'(o_alu_opcode), 32'(tbl[k].op));
            chk("tbl_ac", 32'(o_addr_cal), 32'(tbl[k].ac));
            chk("tbl_cb", 32'(o_con_branch_comp), 32'(tbl[k].cb));
            chk("tbl_rs1", o_rs1_value, tbl[k].v1);
            chk("tbl_rs2", o_rs2_value, tbl[k].v2);
            step();
            chk("tbl_count0", 32'(o_count), 32'd0);
            chk("tbl_ex_en0", 32'(o_ex_en), 32'd0);
        end

        // CDB wakeup of rs1 three cycles after dispatch
        dispatch(8'd4, 5'd1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd1, 1'b1, 32'd7, 8'd0);
        step();
        idle_in();
        #1;
        chk("wk_wait0", 32'(o_ex_en), 32'd0);
        step();
        chk("wk_wait1", 32'(o_ex_en), 32'd0);
        step();
        i_cdb_valid = 1'b1; i_cdb_rob_addr = 8'd1; i_cdb_value = 32'h1234;
        #1;
        chk("wk_no_bypass", 32'(o_ex_en), 32'd0);
        step();
        idle_in();
        #1;
        chk("wk_ex_en", 32'(o_ex_en), 32'd1);
        chk("wk_rob", 32'(o_rob_addr), 32'd4);
        chk("wk_rs1", o_rs1_value, 32'h1234);
        chk("wk_rs2", o_rs2_value, 32'd7);
        step();
        chk("wk_count0", 32'(o_count), 32'd0);

        // both operands wait on the same tag and wake together
        dispatch(8'd3, 5'd2, 1'b0, 1'b0, 1'b0, 32'd0, 8'd5, 1'b0, 32'd0, 8'd5);
        step();
        idle_in();
        i_cdb_valid = 1'b1; i_cdb_rob_addr = 8'd5; i_cdb_value = 32'h55;
        step();
        idle_in();
        #1;
        chk("wk2_ex_en", 32'(o_ex_en), 32'd1);
        chk("wk2_rs1", o_rs1_value, 32'h55);
        chk("wk2_rs2", o_rs2_value, 32'h55);
        step();

        // forwarding of a broadcast in the dispatch cycle
        dispatch(8'd7, 5'd3, 1'b0, 1'b0, 1'b1, 32'h11, 8'd0, 1'b0, 32'd0, 8'd6);
        i_cdb_valid = 1'b1; i_cdb_rob_addr = 8'd6; i_cdb_value = 32'hAA;
        step();
        idle_in();
        #1;
        chk("fwd_ex_en", 32'(o_ex_en), 32'd1);
        chk("fwd_rob", 32'(o_rob_addr), 32'd7);
        chk("fwd_rs1", o_rs1_value, 32'h11);
        chk("fwd_rs2", o_rs2_value, 32'hAA);
        step();

        // fill while busy, reject overflow, scramble indices, drain
        i_alu_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dispatch(8'(10 + k), 5'd0, 1'b0, 1'b0, 1'b1, 32'(k), 8'd0, 1'b1, 32'd0, 8'd0);
            step();
        end
        idle_in();
        #1;
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_count", 32'(o_count), 32'd4);
        chk("fill_busy_ex", 32'(o_ex_en), 32'd0);
        dispatch(8'd14, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 8'd0, 1'b1, 32'd0, 8'd0);
        step();
        chk("fill_reject", 32'(o_count), 32'd4);
        i_alu_busy = 1'b0;
        #1;
        chk("scr_ex_en", 32'(o_ex_en), 32'd1);
        chk("scr_rob", 32'(o_rob_addr), 32'd10);
        step();
        chk("scr_full_reject", 32'(o_count), 32'd3);
        i_alu_busy = 1'b1;
        dispatch(8'd20, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 8'd0, 1'b1, 32'd0, 8'd0);
        step();
        idle_in();
        i_alu_busy = 1'b0;
        #1;
        chk("scr_count4", 32'(o_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_ex_en", 32'(o_ex_en), 32'd1);
            chk("drain_rob", 32'(o_rob_addr), 32'(drain_exp[k]));
            step();
        end
        chk("drain_count", 32'(o_count), 32'd0);
        chk("drain_ex_en0", 32'(o_ex_en), 32'd0);

        // flush with three valid entries and a concurrent dispatch
        i_alu_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dispatch(8'(30 + k), 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 8'd0, 1'b1, 32'd0, 8'd0);
            step();
        end
        idle_in();
        #1;
        chk("fl_count3", 32'(o_count), 32'd3);
        i_alu_busy = 1'b0;
        i_flush = 1'b1;
        dispatch(8'd40, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 8'd0, 1'b1, 32'd0, 8'd0);
        #1;
        chk("fl_ex_en", 32'(o_ex_en), 32'd0);
        chk("fl_rob_zero", 32'(o_rob_addr), 32'd0);
        step();
        idle_in();
        #1;
        chk("fl_count0", 32'(o_count), 32'd0);
        chk("fl_full0", 32'(o_full), 32'd0);
        chk("fl_ex_en_after", 32'(o_ex_en), 32'd0);

        // asynchronous reset mid-cycle with two valid entries
        i_alu_busy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            dispatch(8'(50 + k), 5'd9, 1'b1, 1'b1, 1'b1, 32'h99, 8'd0, 1'b1, 32'h77, 8'd0);
            step();
        end
        idle_in();
        i_alu_busy = 1'b0;
        #1;
        chk("ar_pre_ex_en", 32'(o_ex_en), 32'd1);
        chk("ar_pre_rob", 32'(o_rob_addr), 32'd50);
        #1;
        rstn = 1'b0;
        #1;
        chk("ar_ex_en", 32'(o_ex_en), 32'd0);
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_rob", 32'(o_rob_addr), 32'd0);
        chk("ar_rs1", o_rs1_value, 32'd0);
        chk("ar_op", 32'(o_alu_opcode), 32'd0);
        chk("ar_flags", 32'({o_addr_cal, o_con_branch_comp}), 32'd0);
        step();
        #3;
        rstn = 1'b1;
        step();
        chk("ar_post_ex_en", 32'(o_ex_en), 32'd0);
        step();
        chk("ar_post_count", 32'(o_count), 32'd0);
        chk("ar_post_ex_en2", 32'(o_ex_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
